// File: rtl/axi_rt_bw_pkg.sv
// Shared definitions for the AXI real-time bandwidth regulator: refill modes
// and the byte-cost helper used by every channel gate.
package axi_rt_bw_pkg;

    typedef enum logic {
        ModeRefill     = 1'b0,
        ModeAccumulate = 1'b1
    } carry_mode_e;

    // The largest legal burst (256 beats of 128 bytes) needs exactly 16 bits.
    localparam int unsigned CostWidth = 16;

    function automatic logic [CostWidth-1:0] byteCost(input logic [7:0] len, input logic [2:0] size);
        logic [CostWidth-1:0] beats;
        beats = CostWidth'(len) + CostWidth'(1);
        return beats << size;
    endfunction

endpackage

// File: rtl/axi_rt_bw_chan.sv
// One regulated address channel: byte cost, remaining budget, and the
// grant latch that keeps valid stable once it has been offered downstream.
module axi_rt_bw_chan
    import axi_rt_bw_pkg::*;
#(
    parameter int unsigned BudgetWidth = 32,
    parameter int          CarryOver   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   refill_i,
    input  logic [BudgetWidth-1:0] budget_i,
    input  logic                   cfg_load_i,
    input  logic [BudgetWidth-1:0] cfg_budget_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [7:0]             len_i,
    input  logic [2:0]             size_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [BudgetWidth-1:0] left_o,
    output logic                   blocked_o
);

    localparam int unsigned WideWidth = ((BudgetWidth > CostWidth) ? BudgetWidth : CostWidth) + 1;
    localparam logic [WideWidth-1:0] AllOnes = {{(WideWidth - BudgetWidth){1'b0}}, {BudgetWidth{1'b1}}};

    logic [BudgetWidth-1:0] left_q, left_d;
    logic                   granted_q, granted_d;
    logic [WideWidth-1:0]   costWide;
    logic [BudgetWidth-1:0] cost;
    logic [BudgetWidth-1:0] refillVal;
    logic [BudgetWidth-1:0] base;
    logic                   allowed;
    logic                   handshake;

    axi_rt_bw_regulator_chan #(
        .BudgetWidth (BudgetWidth),
        .CarryOver   (CarryOver)
    ) u_refill (
        .left_i   (left_q),
        .budget_i (budget_i),
        .refill_o (refillVal)
    );

    always_comb begin
        costWide  = WideWidth'(byteCost(len_i, size_i));
        cost      = (costWide > AllOnes) ? {BudgetWidth{1'b1}} : costWide[BudgetWidth-1:0];
        allowed   = !enable_i || granted_q || (left_q >= cost);
        valid_o   = valid_i & allowed;
        ready_o   = ready_i & allowed;
        handshake = valid_o & ready_i;
        blocked_o = enable_i & valid_i & !allowed;
        left_o    = left_q;
    end

    // A config load overrides everything, including a same-cycle refill or consumption.
    always_comb begin
        base      = refill_i ? refillVal : left_q;
        left_d    = left_q;
        granted_d = granted_q;
        if (cfg_load_i) begin
            left_d = cfg_budget_i;
        end else if (enable_i) begin
            left_d = base;
            if (handshake) begin
                left_d = (base > cost) ? (base - cost) : '0;
            end
        end
        if (handshake) begin
            granted_d = 1'b0;
        end else if (valid_o && !ready_i) begin
            granted_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            left_q    <= '0;
            granted_q <= 1'b0;
        end else begin
            left_q    <= left_d;
            granted_q <= granted_d;
        end
    end

endmodule

// File: rtl/axi_rt_bw_regulator_chan.sv
// Compatibility note: the channel gate lives in axi_rt_bw_chan.sv; this file
// only provides the budget-refill helper shared by both channel directions.
module axi_rt_bw_regulator_chan
    import axi_rt_bw_pkg::*;
#(
    parameter int unsigned BudgetWidth = 32,
    parameter int          CarryOver   = 0
) (
    input  logic [BudgetWidth-1:0] left_i,
    input  logic [BudgetWidth-1:0] budget_i,
    output logic [BudgetWidth-1:0] refill_o
);

    localparam int unsigned WideWidth = BudgetWidth + 1;
    localparam logic [WideWidth-1:0] AllOnes = {1'b0, {BudgetWidth{1'b1}}};

    logic [WideWidth-1:0] sumWide;
    logic [WideWidth-1:0] capWide;
    logic [WideWidth-1:0] minWide;

    // Accumulating refill is capped at twice the budget and then clipped to the counter width.
    always_comb begin
        sumWide = WideWidth'(left_i) + WideWidth'(budget_i);
        capWide = WideWidth'(budget_i) << 1;
        minWide = (sumWide < capWide) ? sumWide : capWide;
        if (CarryOver == int'(ModeAccumulate)) begin
            refill_o = (minWide > AllOnes) ? {BudgetWidth{1'b1}} : minWide[BudgetWidth-1:0];
        end else begin
            refill_o = budget_i;
        end
    end

endmodule

// File: rtl/axi_rt_bw_regulator.sv
// Per-manager AXI AW/AR bandwidth regulator: each manager gets its own read and
// write byte budget refilled on a private period counter.
module axi_rt_bw_regulator
    import axi_rt_bw_pkg::*;
#(
    parameter int unsigned NumManagers = 2,
    parameter int unsigned BudgetWidth = 32,
    parameter int unsigned PeriodWidth = 32,
    parameter int          CarryOver   = 0,
    localparam int unsigned IdxWidth   = (NumManagers > 1) ? $clog2(NumManagers) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumManagers-1:0]                  aw_valid_i,
    output logic [NumManagers-1:0]                  aw_ready_o,
    input  logic [NumManagers-1:0][7:0]             aw_len_i,
    input  logic [NumManagers-1:0][2:0]             aw_size_i,
    output logic [NumManagers-1:0]                  aw_valid_o,
    input  logic [NumManagers-1:0]                  aw_ready_i,
    input  logic [NumManagers-1:0]                  ar_valid_i,
    output logic [NumManagers-1:0]                  ar_ready_o,
    input  logic [NumManagers-1:0][7:0]             ar_len_i,
    input  logic [NumManagers-1:0][2:0]             ar_size_i,
    output logic [NumManagers-1:0]                  ar_valid_o,
    input  logic [NumManagers-1:0]                  ar_ready_i,
    input  logic                                    cfg_we_i,
    input  logic [IdxWidth-1:0]                     cfg_idx_i,
    input  logic                                    cfg_enable_i,
    input  logic [BudgetWidth-1:0]                  cfg_w_budget_i,
    input  logic [BudgetWidth-1:0]                  cfg_r_budget_i,
    input  logic [PeriodWidth-1:0]                  cfg_period_i,
    output logic [NumManagers-1:0][BudgetWidth-1:0] w_left_o,
    output logic [NumManagers-1:0][BudgetWidth-1:0] r_left_o,
    output logic [NumManagers-1:0]                  isolated_o
);

    logic [NumManagers-1:0]                  enable_q, enable_d;
    logic [NumManagers-1:0][BudgetWidth-1:0] wBudget_q, wBudget_d;
    logic [NumManagers-1:0][BudgetWidth-1:0] rBudget_q, rBudget_d;
    logic [NumManagers-1:0][PeriodWidth-1:0] period_q, period_d;
    logic [NumManagers-1:0][PeriodWidth-1:0] periodCnt_q, periodCnt_d;
    logic [NumManagers-1:0][PeriodWidth-1:0] lastCount;
    logic [NumManagers-1:0]                  cfgHit;
    logic [NumManagers-1:0]                  refill;
    logic [NumManagers-1:0]                  awBlocked;
    logic [NumManagers-1:0]                  arBlocked;

    // A programmed period of zero behaves like one: refill on every cycle.
    always_comb begin
        for (int m = 0; m < NumManagers; m++) begin
            cfgHit[m]    = cfg_we_i && (cfg_idx_i == IdxWidth'(m));
            lastCount[m] = (period_q[m] == '0) ? '0 : (period_q[m] - 1'b1);
            refill[m]    = enable_q[m] && (periodCnt_q[m] == lastCount[m]);
        end
    end

    always_comb begin
        enable_d    = enable_q;
        wBudget_d   = wBudget_q;
        rBudget_d   = rBudget_q;
        period_d    = period_q;
        periodCnt_d = periodCnt_q;
        for (int m = 0; m < NumManagers; m++) begin
            if (cfgHit[m]) begin
                enable_d[m]    = cfg_enable_i;
                wBudget_d[m]   = cfg_w_budget_i;
                rBudget_d[m]   = cfg_r_budget_i;
                period_d[m]    = cfg_period_i;
                periodCnt_d[m] = '0;
            end else if (enable_q[m]) begin
                periodCnt_d[m] = refill[m] ? '0 : (periodCnt_q[m] + 1'b1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q    <= '0;
            wBudget_q   <= '0;
            rBudget_q   <= '0;
            period_q    <= '0;
            periodCnt_q <= '0;
        end else begin
            enable_q    <= enable_d;
            wBudget_q   <= wBudget_d;
            rBudget_q   <= rBudget_d;
            period_q    <= period_d;
            periodCnt_q <= periodCnt_d;
        end
    end

    for (genvar m = 0; m < NumManagers; m++) begin : gen_mgr
        axi_rt_bw_chan #(
            .BudgetWidth (BudgetWidth),
            .CarryOver   (CarryOver)
        ) u_aw (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .enable_i     (enable_q[m]),
            .refill_i     (refill[m]),
            .budget_i     (wBudget_q[m]),
            .cfg_load_i   (cfgHit[m]),
            .cfg_budget_i (cfg_w_budget_i),
            .valid_i      (aw_valid_i[m]),
            .ready_o      (aw_ready_o[m]),
            .len_i        (aw_len_i[m]),
            .size_i       (aw_size_i[m]),
            .valid_o      (aw_valid_o[m]),
            .ready_i      (aw_ready_i[m]),
            .left_o       (w_left_o[m]),
            .blocked_o    (awBlocked[m])
        );

        axi_rt_bw_chan #(
            .BudgetWidth (BudgetWidth),
            .CarryOver   (CarryOver)
        ) u_ar (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .enable_i     (enable_q[m]),
            .refill_i     (refill[m]),
            .budget_i     (rBudget_q[m]),
            .cfg_load_i   (cfgHit[m]),
            .cfg_budget_i (cfg_r_budget_i),
            .valid_i      (ar_valid_i[m]),
            .ready_o      (ar_ready_o[m]),
            .len_i        (ar_len_i[m]),
            .size_i       (ar_size_i[m]),
            .valid_o      (ar_valid_o[m]),
            .ready_i      (ar_ready_i[m]),
            .left_o       (r_left_o[m]),
            .blocked_o    (arBlocked[m])
        );

        assign isolated_o[m] = awBlocked[m] | arBlocked[m];
    end

endmodule

// File: tb/tb_axi_rt_bw_regulator.sv
// Directed bench for axi_rt_bw_regulator: a refill-to-budget instance and an
// accumulating instance share one stimulus stream and one expected-value queue.
module tb_axi_rt_bw_regulator;

    localparam int NM = 2;
    localparam int BW = 32;
    localparam int PW = 32;

    logic                   clk;
    logic                   rst;
    logic [NM-1:0]          awValid, awReadyIn, arValid, arReadyIn;
    logic [NM-1:0][7:0]     awLen, arLen;
    logic [NM-1:0][2:0]     awSize, arSize;
    logic                   cfgWe;
    logic [0:0]             cfgIdx;
    logic                   cfgEnable;
    logic [BW-1:0]          cfgWBudget, cfgRBudget;
    logic [PW-1:0]          cfgPeriod;

    logic [NM-1:0]          awReadyOut, awValidOut, arReadyOut, arValidOut, isolated;
    logic [NM-1:0][BW-1:0]  wLeft, rLeft;
    logic [NM-1:0]          awReadyOutCo, awValidOutCo, arReadyOutCo, arValidOutCo, isolatedCo;
    logic [NM-1:0][BW-1:0]  wLeftCo, rLeftCo;

    logic [31:0]            expQ[$];
    int                     compared   = 0;
    int                     mismatched = 0;

    axi_rt_bw_regulator #(
        .NumManagers (NM), .BudgetWidth (BW), .PeriodWidth (PW), .CarryOver (0)
    ) dut (
        .clk_i (clk), .rst_i (rst),
        .aw_valid_i (awValid), .aw_ready_o (awReadyOut), .aw_len_i (awLen), .aw_size_i (awSize),
        .aw_valid_o (awValidOut), .aw_ready_i (awReadyIn),
        .ar_valid_i (arValid), .ar_ready_o (arReadyOut), .ar_len_i (arLen), .ar_size_i (arSize),
        .ar_valid_o (arValidOut), .ar_ready_i (arReadyIn),
        .cfg_we_i (cfgWe), .cfg_idx_i (cfgIdx), .cfg_enable_i (cfgEnable),
        .cfg_w_budget_i (cfgWBudget), .cfg_r_budget_i (cfgRBudget), .cfg_period_i (cfgPeriod),
        .w_left_o (wLeft), .r_left_o (rLeft), .isolated_o (isolated)
    );

    axi_rt_bw_regulator #(
        .NumManagers (NM), .BudgetWidth (BW), .PeriodWidth (PW), .CarryOver (1)
    ) dutCo (
        .clk_i (clk), .rst_i (rst),
        .aw_valid_i (awValid), .aw_ready_o (awReadyOutCo), .aw_len_i (awLen), .aw_size_i (awSize),
        .aw_valid_o (awValidOutCo), .aw_ready_i (awReadyIn),
        .ar_valid_i (arValid), .ar_ready_o (arReadyOutCo), .ar_len_i (arLen), .ar_size_i (arSize),
        .ar_valid_o (arValidOutCo), .ar_ready_i (arReadyIn),
        .cfg_we_i (cfgWe), .cfg_idx_i (cfgIdx), .cfg_enable_i (cfgEnable),
        .cfg_w_budget_i (cfgWBudget), .cfg_r_budget_i (cfgRBudget), .cfg_period_i (cfgPeriod),
        .w_left_o (wLeftCo), .r_left_o (rLeftCo), .isolated_o (isolatedCo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit isAr, input int m, input bit valid,
                                 input logic [7:0] len, input logic [2:0] size, input bit ready);
        if (isAr) begin
            arValid[m] = valid; arLen[m] = len; arSize[m] = size; arReadyIn[m] = ready;
        end else begin
            awValid[m] = valid; awLen[m] = len; awSize[m] = size; awReadyIn[m] = ready;
        end
        #1;
    endtask

    // Config write lands on the next rising edge; returns just after it.
    task automatic configure(input logic [0:0] idx, input bit en, input logic [BW-1:0] wb,
                             input logic [BW-1:0] rb, input logic [PW-1:0] period);
        cfgWe = 1'b1; cfgIdx = idx; cfgEnable = en;
        cfgWBudget = wb; cfgRBudget = rb; cfgPeriod = period;
        tick();
        cfgWe = 1'b0;
    endtask

    task automatic expectValue(input logic [31:0] v);
        expQ.push_back(v);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL %s observed=%0d expected=<empty queue>", tag, observed);
        end else begin
            expected = expQ.pop_front();
            assert (observed === expected) else begin
                mismatched++;
                $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        awValid = '0; awReadyIn = '0; awLen = '0; awSize = '0;
        arValid = '0; arReadyIn = '0; arLen = '0; arSize = '0;
        cfgWe = 1'b0; cfgIdx = '0; cfgEnable = 1'b0;
        cfgWBudget = '0; cfgRBudget = '0; cfgPeriod = '0;

        // Reset state: passthrough with zeroed status.
        applyStimulus(1'b0, 0, 1'b1, 8'd3, 3'd3, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();
        expectValue(1);  checkOutput("rst_aw_valid_pass", awValidOut[0]);
        expectValue(0);  checkOutput("rst_aw_ready_pass", awReadyOut[0]);
        expectValue(0);  checkOutput("rst_isolated", isolated);
        expectValue(0);  checkOutput("rst_w_left0", wLeft[0]);
        expectValue(0);  checkOutput("rst_r_left1", rLeft[1]);
        applyStimulus(1'b0, 0, 1'b1, 8'd3, 3'd3, 1'b1);
        expectValue(1);  checkOutput("rst_aw_ready_follow", awReadyOut[0]);
        applyStimulus(1'b0, 0, 1'b0, 8'd0, 3'd0, 1'b0);

        // Budget 256, period 100, 32-byte bursts back to back.
        configure(1'b0, 1'b1, 256, 256, 100);
        applyStimulus(1'b0, 0, 1'b1, 8'd3, 3'd3, 1'b1);
        for (int k = 0; k <= 100; k++) begin
            expectValue((k < 8 || k == 100) ? 1 : 0);
            checkOutput($sformatf("stream_valid_c%0d", k), awValidOut[0]);
            expectValue((k < 8 || k == 100) ? 0 : 1);
            checkOutput($sformatf("stream_iso_c%0d", k), isolated);
            if (k == 8) begin
                expectValue(0);   checkOutput("stream_left_exhausted", wLeft[0]);
            end
            if (k == 100) begin
                expectValue(256); checkOutput("stream_left_refilled", wLeft[0]);
            end
            tick();
        end
        applyStimulus(1'b0, 0, 1'b0, 8'd0, 3'd0, 1'b1);
        expectValue(224); checkOutput("stream_left_after_refill", wLeft[0]);

        // 16-byte handshake exactly on the refill edge.
        configure(1'b0, 1'b1, 64, 64, 4);
        applyStimulus(1'b0, 0, 1'b1, 8'd3, 3'd3, 1'b1);
        expectValue(1);  checkOutput("edge_first_valid", awValidOut[0]);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 8'd0, 3'd0, 1'b1);
        expectValue(32); checkOutput("edge_left_after_first", wLeft[0]);
        tick(); tick();
        applyStimulus(1'b0, 0, 1'b1, 8'd1, 3'd3, 1'b1);
        expectValue(1);  checkOutput("edge_refill_valid", awValidOut[0]);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 8'd0, 3'd0, 1'b1);
        expectValue(48); checkOutput("edge_left_refill_minus16", wLeft[0]);

        // Offered request stays valid while the budget shrinks beneath it.
        configure(1'b0, 1'b1, 32, 32, 1000);
        applyStimulus(1'b0, 0, 1'b1, 8'd3, 3'd3, 1'b0);
        expectValue(1);  checkOutput("hold_valid_c0", awValidOut[0]);
        tick();
        expectValue(1);  checkOutput("hold_valid_c1", awValidOut[0]);
        configure(1'b0, 1'b1, 16, 16, 1000);
        expectValue(16); checkOutput("hold_left_reloaded", wLeft[0]);
        expectValue(0);  checkOutput("hold_not_isolated", isolated);
        for (int k = 2; k <= 4; k++) begin
            expectValue(1); checkOutput($sformatf("hold_valid_c%0d", k), awValidOut[0]);
            tick();
        end
        applyStimulus(1'b0, 0, 1'b1, 8'd3, 3'd3, 1'b1);
        expectValue(1);  checkOutput("hold_valid_handshake", awValidOut[0]);
        expectValue(1);  checkOutput("hold_ready_handshake", awReadyOut[0]);
        tick();
        expectValue(0);  checkOutput("hold_left_saturated", wLeft[0]);
        expectValue(0);  checkOutput("blocked_valid", awValidOut[0]);
        expectValue(0);  checkOutput("blocked_ready", awReadyOut[0]);
        expectValue(1);  checkOutput("blocked_iso", isolated);

        // Manager 1 reads stream freely while manager 0 is starved.
        configure(1'b1, 1'b1, 4096, 4096, 1000);
        applyStimulus(1'b1, 1, 1'b1, 8'd0, 3'd2, 1'b1);
        for (int k = 0; k < 5; k++) begin
            expectValue(1); checkOutput($sformatf("indep_ar1_valid_c%0d", k), arValidOut[1]);
            expectValue(1); checkOutput($sformatf("indep_iso_c%0d", k), isolated);
            tick();
        end
        expectValue(4076); checkOutput("indep_r_left1", rLeft[1]);
        expectValue(4096); checkOutput("indep_w_left1", wLeft[1]);
        expectValue(0);    checkOutput("indep_aw0_still_blocked", awValidOut[0]);

        // Reset pulse while manager 0 is blocked.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expectValue(1); checkOutput("rstmid_aw_valid_pass", awValidOut[0]);
        expectValue(0); checkOutput("rstmid_isolated", isolated);
        expectValue(0); checkOutput("rstmid_w_left0", wLeft[0]);
        expectValue(0); checkOutput("rstmid_r_left1", rLeft[1]);
        applyStimulus(1'b0, 0, 1'b0, 8'd0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1, 1'b0, 8'd0, 3'd0, 1'b0);

        // Idle accumulation: capped at twice the budget.
        configure(1'b0, 1'b1, 64, 64, 10);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 9) begin
                expectValue(64);  checkOutput("carry_before_refill", wLeftCo[0]);
            end
            if (k == 10) begin
                expectValue(128); checkOutput("carry_first_refill", wLeftCo[0]);
            end
        end
        expectValue(128); checkOutput("carry_capped", wLeftCo[0]);
        expectValue(64);  checkOutput("nocarry_budget", wLeft[0]);

        // Period zero refills every cycle; config write beats a same-cycle handshake.
        configure(1'b0, 1'b1, 64, 64, 0);
        applyStimulus(1'b0, 0, 1'b1, 8'd3, 3'd3, 1'b1);
        expectValue(1);  checkOutput("p0_valid", awValidOut[0]);
        tick();
        applyStimulus(1'b0, 0, 1'b0, 8'd0, 3'd0, 1'b1);
        expectValue(32); checkOutput("p0_left_refill_minus32", wLeft[0]);
        tick();
        expectValue(64); checkOutput("p0_left_refilled", wLeft[0]);
        applyStimulus(1'b0, 0, 1'b1, 8'd3, 3'd3, 1'b1);
        configure(1'b0, 1'b1, 100, 100, 50);
        applyStimulus(1'b0, 0, 1'b0, 8'd0, 3'd0, 1'b1);
        expectValue(100); checkOutput("cfg_wins_over_handshake", wLeft[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
